// File: rtl/led_scan_driver_pkg.sv
// Shared constants and types for the guess-LED scan driver.
package led_scan_driver_pkg;

  localparam int unsigned NUM_LEDS = 4;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned POS_W    = 2;

  localparam int unsigned RED   = 0;
  localparam int unsigned GREEN = 1;
  localparam int unsigned BLUE  = 2;

  localparam logic [COLOR_W-1:0] COLOR_OFF = 3'b000;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } slot_phase_e;

  // Frame-stable copy of the guess-entry inputs
  typedef struct packed {
    logic                                enable;
    logic [POS_W-1:0]                    blink_led;
    logic [NUM_LEDS-1:0][COLOR_W-1:0]    color;
  } snapshot_t;

endpackage

// File: rtl/led_scan_driver_scan_counter.sv
// Modulo counter with terminal-value wrap pulse and look-ahead count.
module scan_counter #(
  parameter int unsigned MODULUS   = 2,
  parameter int unsigned RESET_VAL = 0,
  localparam int unsigned W        = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count_nxt_c,
  output logic         wrap_c
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] count;

  always_comb begin
    wrap_c      = en && (count == LAST);
    count_nxt_c = count;
    if (clr || wrap_c) begin
      count_nxt_c = '0;
    end else if (en) begin
      count_nxt_c = count + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= W'(RESET_VAL);
    end else begin
      count <= count_nxt_c;
    end
  end

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed RGB driver for the four guess-position LEDs with
// per-slot blanking and frame-synchronous blink of one position.
module led_scan_driver
  import led_scan_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [2:0]   led_zero,
  input  logic [2:0]   led_one,
  input  logic [2:0]   led_two,
  input  logic [2:0]   led_three,
  input  logic [1:0]   blink_led,
  output logic [2:0]   rgb,
  output logic [3:0]   an,
  output logic         frame_tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  logic [CNT_W-1:0]   cnt_nxt;
  logic               slot_wrap;
  logic               boundary_c;
  logic [FC_W-1:0]    fc_nxt_unused;
  logic               fc_wrap;

  logic [POS_W-1:0]   pos, pos_nxt;
  snapshot_t          snap, snap_nxt;
  logic               blink_phase, blink_nxt;
  slot_phase_e        phase_nxt;
  logic               dark;
  logic [COLOR_W-1:0] color_sel;
  logic [NUM_LEDS-1:0] an_nxt;
  logic [COLOR_W-1:0] rgb_nxt;
  logic               tick_nxt;

  scan_counter #(
    .MODULUS   (SCAN_DIV),
    .RESET_VAL (SCAN_DIV - 1)
  ) u_slot (
    .clk         (clk),
    .rst         (rst),
    .en          (1'b1),
    .clr         (1'b0),
    .count_nxt_c (cnt_nxt),
    .wrap_c      (slot_wrap)
  );

  assign boundary_c = slot_wrap && (pos == POS_LAST);

  // Frame counter restarts whenever the captured enable is low
  scan_counter #(
    .MODULUS   (BLINK_FRAMES),
    .RESET_VAL (0)
  ) u_frame (
    .clk         (clk),
    .rst         (rst),
    .en          (boundary_c),
    .clr         (boundary_c && !enable),
    .count_nxt_c (fc_nxt_unused),
    .wrap_c      (fc_wrap)
  );

  // Outputs are computed from next-state so they register in step with cnt/pos
  always_comb begin
    pos_nxt   = pos;
    snap_nxt  = snap;
    blink_nxt = blink_phase;
    phase_nxt = BLANK;
    dark      = 1'b0;
    color_sel = COLOR_OFF;
    an_nxt    = '1;
    rgb_nxt   = COLOR_OFF;
    tick_nxt  = boundary_c;

    if (slot_wrap) begin
      pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    end

    if (boundary_c) begin
      snap_nxt.enable    = enable;
      snap_nxt.blink_led = blink_led;
      snap_nxt.color     = {led_three, led_two, led_one, led_zero};
      if (!enable) begin
        blink_nxt = 1'b0;
      end else if (fc_wrap) begin
        blink_nxt = ~blink_phase;
      end
    end

    if (32'(cnt_nxt) >= BLANK_CYCLES) begin
      phase_nxt = DRIVE;
    end

    dark = snap_nxt.enable && blink_nxt && (snap_nxt.blink_led == pos_nxt);

    if ((phase_nxt == DRIVE) && !dark) begin
      an_nxt[pos_nxt] = 1'b0;
      color_sel       = snap_nxt.color[pos_nxt];
      rgb_nxt[RED]    = color_sel[RED];
      rgb_nxt[GREEN]  = color_sel[GREEN];
      rgb_nxt[BLUE]   = color_sel[BLUE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos         <= POS_LAST;
      snap        <= '0;
      blink_phase <= 1'b0;
      an          <= '1;
      rgb         <= COLOR_OFF;
      frame_tick  <= 1'b0;
    end else begin
      pos         <= pos_nxt;
      snap        <= snap_nxt;
      blink_phase <= blink_nxt;
      an          <= an_nxt;
      rgb         <= rgb_nxt;
      frame_tick  <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Scoreboard bench for led_scan_driver with a small scan geometry.
module tb_led_scan_driver;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] led_zero, led_one, led_two, led_three;
  logic [1:0] blink_led;
  logic [2:0] rgb;
  logic [3:0] an;
  logic       frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_scan_driver #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .led_zero   (led_zero),
    .led_one    (led_one),
    .led_two    (led_two),
    .led_three  (led_three),
    .blink_led  (blink_led),
    .rgb        (rgb),
    .an         (an),
    .frame_tick (frame_tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: position in frame from edge count, blink from enabled-frame run length
  logic [7:0] exp_q[$];
  int         e     = 0;
  int         m_k   = -1;
  int         en_run = 0;
  logic       m_phase = 1'b0;
  logic       s_en = 1'b0;
  logic [1:0] s_bl = 2'd0;
  logic [2:0] s_col[4];

  function automatic logic [7:0] exp_of(input int k);
    int         p;
    int         c;
    logic [3:0] a;
    logic [2:0] r;
    p = k / SD;
    c = k % SD;
    a = 4'hF;
    r = 3'b000;
    if (c >= BC && !(s_en && m_phase && p == int'(s_bl))) begin
      a[p] = 1'b0;
      r    = s_col[p];
    end
    return {a, r, (k == 0)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e       = 0;
      m_k     = -1;
      en_run  = 0;
      m_phase = 1'b0;
      s_en    = 1'b0;
      s_bl    = 2'd0;
      for (int i = 0; i < 4; i++) s_col[i] = 3'b000;
      exp_q.push_back(8'b1111_000_0);
    end else begin
      m_k = e % FRAME;
      e++;
      if (m_k == 0) begin
        s_en     = enable;
        s_bl     = blink_led;
        s_col[0] = led_zero;
        s_col[1] = led_one;
        s_col[2] = led_two;
        s_col[3] = led_three;
        en_run   = enable ? en_run + 1 : 0;
        m_phase  = ((en_run / BF) % 2) == 1;
      end
      exp_q.push_back(exp_of(m_k));
    end
  end

  always @(negedge clk) begin
    logic [7:0] x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check_eq("scan{an,rgb,tick}", {24'd0, an, rgb, frame_tick}, {24'd0, x});
    end
  end

  task automatic wait_k(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_k != k && n < 2 * FRAME);
    check_eq("sync_k", m_k, k);
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    led_zero  = 3'd1;
    led_one   = 3'd2;
    led_two   = 3'd4;
    led_three = 3'd7;
    blink_led = 2'd0;
    for (int i = 0; i < 4; i++) s_col[i] = 3'b000;

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_eq("post_release_an", an, 4'hF);

    // Solid display, two frames
    repeat (2 * FRAME) @(negedge clk);
    wait_k(SD + BC);
    check_eq("slot1_an", an, 4'b1101);
    check_eq("slot1_rgb", rgb, 3'd2);

    // Blink position 2, then a mid-frame colour change on position 1
    enable    = 1'b1;
    blink_led = 2'd2;
    repeat (3 * FRAME) @(negedge clk);
    wait_k(3);
    led_one = 3'd5;
    wait_k(SD + 4);
    check_eq("midframe_hold_rgb", rgb, 3'd2);
    wait_k(SD + 4);
    check_eq("nextframe_rgb", rgb, 3'd5);

    // Drop enable during a dark frame
    for (int f = 0; f < 8; f++) begin
      wait_k(2 * SD + 4);
      if (m_phase) break;
    end
    check_eq("blink_dark_an", an, 4'hF);
    check_eq("blink_dark_rgb", rgb, 3'd0);
    enable = 1'b0;
    wait_k(2 * SD + 4);
    check_eq("solid_after_en_an", an, 4'b1011);
    check_eq("solid_after_en_rgb", rgb, 3'd4);

    // Colour code 0 still selects the LED
    led_three = 3'd0;
    repeat (FRAME) @(negedge clk);
    wait_k(3 * SD + 6);
    check_eq("off_colour_an", an, 4'b0111);
    check_eq("off_colour_rgb", rgb, 3'd0);

    // Asynchronous reset mid-drive at pos 1
    wait_k(SD + 4);
    check_eq("pre_rst_an", an, 4'b1101);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_an", an, 4'hF);
    check_eq("rst_rgb", rgb, 3'd0);
    check_eq("rst_tick", frame_tick, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check_eq("first_edge_tick", frame_tick, 1'b1);
    repeat (FRAME + 8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
